// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small byte FIFO in front of it.
// Bytes written by the CPU are sent as 8N1 frames, LSB first.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] w_data,
  input  logic       we,
  output logic       tx,
  output logic       full,
  output logic       empty,
  output logic       tx_busy
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW = FIFO_AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TICK_ONE = TW'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [CW-1:0]      count;
  logic [CW-1:0]      count_next;

  state_t             state;
  logic [TW-1:0]      tick;
  logic [2:0]         bit_cnt;
  logic [7:0]         shift;

  logic tick_last;
  logic push;
  logic pop;

  assign tick_last = (tick == TICK_LAST);
  assign push = we && !full;
  // Pop happens when idle or on the final stop-bit cycle,
  // so back-to-back frames have no gap.
  assign pop = !empty &&
               (state == IDLE || (state == STOP && tick_last));

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + CNT_ONE;
    else if (!push && pop)
      count_next = count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= w_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)
        rd_ptr <= rd_ptr + PTR_ONE;
      count <= count_next;
      full  <= (count_next == CNT_FULL);
      empty <= (count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shift   <= mem[rd_ptr];
            tick    <= '0;
            bit_cnt <= '0;
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (tick_last) begin
            tick  <= '0;
            state <= DATA;
            tx    <= shift[0];
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        DATA: begin
          if (tick_last) begin
            tick    <= '0;
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              tx <= shift[1];
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        STOP: begin
          if (tick_last) begin
            tick <= '0;
            if (pop) begin
              shift   <= mem[rd_ptr];
              bit_cnt <= '0;
              state   <= START;
              tx      <= 1'b0;
            end else begin
              state   <= IDLE;
              tx      <= 1'b1;
              tx_busy <= 1'b0;
            end
          end else begin
            tick <= tick + TICK_ONE;
          end
        end
        default: begin
          state   <= IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed and random writes checked
// cycle by cycle against a frame-level queue model.
module tb_uart_tx_fifo;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] w_data;
  logic       we;
  logic       tx;
  logic       full;
  logic       empty;
  logic       tx_busy;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] q[$];
  int         pos = -1;
  logic [7:0] cur = 8'h00;

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_AW(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .w_data(w_data),
    .we(we),
    .tx(tx),
    .full(full),
    .empty(empty),
    .tx_busy(tx_busy)
  );

  function automatic logic exp_tx();
    int b;
    if (pos < 0) return 1'b1;
    b = pos / CPB;
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return cur[b-1];
  endfunction

  // pos is the cycle index within the frame on the line, -1 when idle
  task automatic model_edge(input logic r, input logic w,
                            input logic [7:0] d);
    bit do_pop;
    bit do_push;
    if (r) begin
      q.delete();
      pos = -1;
      return;
    end
    do_pop = (pos < 0 || pos == FRAME - 1) && q.size() > 0;
    do_push = w && q.size() < DEPTH;
    if (do_pop) begin
      cur = q.pop_front();
      pos = 0;
    end else if (pos >= 0) begin
      pos = (pos == FRAME - 1) ? -1 : pos + 1;
    end
    if (do_push) q.push_back(d);
  endtask

  task automatic check(input string tag, input logic obs,
                       input logic expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %b expected %b at %0t",
                tag, obs, expv, $time);
  endtask

  task automatic step(input logic r, input logic w,
                      input logic [7:0] d);
    reset = r;
    we = w;
    w_data = d;
    @(posedge clk);
    model_edge(r, w, d);
    #1;
    check("tx", tx, exp_tx());
    check("full", full, q.size() == DEPTH);
    check("empty", empty, q.size() == 0);
    check("tx_busy", tx_busy, pos >= 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((pos >= 0 || q.size() > 0) && n < 1000) begin
      step(1'b0, 1'b0, 8'h00);
      n++;
    end
    check("drain_bound", n < 1000, 1'b1);
    step(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    logic [9:0] frame;
    int n;
    int sent;
    int low;

    reset = 1'b1;
    we = 1'b0;
    w_data = 8'h00;

    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("rst_tx", tx, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    check("rst_busy", tx_busy, 1'b0);
    step(1'b0, 1'b0, 8'h00);

    // single 0xA5 against a literal waveform
    frame = {1'b1, 8'hA5, 1'b0};
    step(1'b0, 1'b1, 8'hA5);
    check("a5_empty", empty, 1'b0);
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 1'b0, 8'h00);
      check("a5_frame", tx, frame[i/CPB]);
      check("a5_busy", tx_busy, 1'b1);
    end
    step(1'b0, 1'b0, 8'h00);
    check("a5_busy_end", tx_busy, 1'b0);
    drain();

    // reset in the middle of a frame
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h5A);
    repeat (15) step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("mid_rst_tx", tx, 1'b1);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_busy", tx_busy, 1'b0);
    repeat (50) begin
      step(1'b0, 1'b0, 8'h00);
      check("rst_quiet", tx, 1'b1);
    end

    // fill and overflow
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 8'(i + 1));
      if (i == 4) check("fill_full", full, 1'b1);
    end
    drain();

    // write while full on the popping cycle
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
    check("pp_full", full, 1'b1);
    n = 0;
    while (q.size() == DEPTH && n < 100) begin
      step(1'b0, 1'b1, 8'hEE);
      n++;
    end
    check("pp_bound", n < 100, 1'b1);
    check("pp_full_drop", full, 1'b0);
    check("pp_not_empty", empty, 1'b0);
    drain();

    // pointer wrap: 10 bytes paced by full
    sent = 0;
    n = 0;
    while (sent < 10 && n < 2000) begin
      if (!full) begin
        step(1'b0, 1'b1, 8'(8'h30 + sent));
        sent++;
      end else begin
        step(1'b0, 1'b0, 8'h00);
      end
      n++;
    end
    check("wrap_bound", n < 2000, 1'b1);
    drain();

    // extreme data values
    low = 0;
    step(1'b0, 1'b1, 8'h00);
    repeat (FRAME + 1) begin
      step(1'b0, 1'b0, 8'h00);
      if (tx == 1'b0) low++;
    end
    check("zeros_low", low == 9 * CPB, 1'b1);
    drain();
    low = 0;
    step(1'b0, 1'b1, 8'hFF);
    repeat (FRAME + 1) begin
      step(1'b0, 1'b0, 8'h00);
      if (tx == 1'b0) low++;
    end
    check("ones_low", low == CPB, 1'b1);
    drain();

    // random traffic with occasional resets
    repeat (3000) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) == 0,
           8'($urandom));
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
